// File: rtl/aes_round_key_sequencer_if.sv
// Bus bundle between the round-key sequencer, the key expander, the key input
// port and the round engine; master is the sequencer side.
interface aes_round_key_sequencer_if;
    logic         key_load;
    logic [127:0] key_in;
    logic         key_ready;
    logic         abort;
    logic         kx_start;
    logic [127:0] kx_key;
    logic         kx_next;
    logic [31:0]  kx_round_key;
    logic [5:0]   kx_word_addr;
    logic         kx_ready;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         busy;
    logic         seq_err;

    modport master (
        input  key_load, key_in, abort, kx_round_key, kx_word_addr, kx_ready, rk_ready,
        output key_ready, kx_start, kx_key, kx_next, rk_valid, rk_data, rk_round, rk_last,
               busy, seq_err
    );

    modport slave (
        output key_load, key_in, abort, kx_round_key, kx_word_addr, kx_ready, rk_ready,
        input  key_ready, kx_start, kx_key, kx_next, rk_valid, rk_data, rk_round, rk_last,
               busy, seq_err
    );
endinterface

// File: rtl/aes_round_key_sequencer.sv
// Drives an on-the-fly AES-128 key expander and presents whole round keys 0..LAST_ROUND.
// Optional word-address checking is enabled with macro AES_RKSEQ_CHECK_EN.
module aes_round_key_sequencer #(
    parameter int unsigned LAST_ROUND = 10
) (
    input logic                         clk,
    input logic                         rst_n,
    aes_round_key_sequencer_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GATHER  = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [3:0] LAST_RND = 4'(LAST_ROUND);

    state_e       state_q, state_d;
    logic [1:0]   slot_q, slot_d;
    logic [127:0] rk_data_q, rk_data_d;
    logic [3:0]   rk_round_q, rk_round_d;
    logic         idle_s;
    logic         kx_start_s;
    logic         kx_next_s;
    logic         word_ok_s;

`ifdef AES_RKSEQ_CHECK_EN
    logic         seq_err_q, seq_err_d;

    // Expected expander word index is 4*round + slot, i.e. {round, slot}.
    assign word_ok_s   = (bus.kx_word_addr == {rk_round_q, slot_q});
    assign bus.seq_err = seq_err_q;
`else
    logic         unused_addr_s;

    assign unused_addr_s = ^bus.kx_word_addr;
    assign word_ok_s     = 1'b1;
    assign bus.seq_err   = 1'b0;
`endif

    assign idle_s     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign kx_start_s = bus.key_load && idle_s && !bus.abort;

    assign bus.key_ready = idle_s;
    assign bus.kx_start  = kx_start_s;
    assign bus.kx_key    = bus.key_in;
    assign bus.kx_next   = kx_next_s;
    assign bus.rk_valid  = (state_q == ST_PRESENT);
    assign bus.rk_data   = rk_data_q;
    assign bus.rk_round  = rk_round_q;
    assign bus.rk_last   = (state_q == ST_PRESENT) && (rk_round_q == LAST_RND);
    assign bus.busy      = (state_q == ST_GATHER) || (state_q == ST_PRESENT);

    // Next-state, word gathering and expander advance decisions.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        rk_data_d  = rk_data_q;
        rk_round_d = rk_round_q;
        kx_next_s  = 1'b0;
`ifdef AES_RKSEQ_CHECK_EN
        seq_err_d  = seq_err_q;
`endif
        if (bus.abort) begin
            state_d = ST_IDLE;
            slot_d  = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.key_load) begin
                        state_d    = ST_GATHER;
                        slot_d     = 2'd0;
                        rk_round_d = 4'd0;
`ifdef AES_RKSEQ_CHECK_EN
                        seq_err_d  = 1'b0;
`endif
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_GATHER: begin
                    if (!bus.kx_ready) begin
                        slot_d = slot_q;
                    end else if (!word_ok_s) begin
                        // Out-of-sequence word: drop it and fall back to idle.
                        state_d   = ST_IDLE;
                        slot_d    = 2'd0;
`ifdef AES_RKSEQ_CHECK_EN
                        seq_err_d = 1'b1;
`endif
                    end else begin
                        case (slot_q)
                            2'd0:    rk_data_d[127:96] = bus.kx_round_key;
                            2'd1:    rk_data_d[95:64]  = bus.kx_round_key;
                            2'd2:    rk_data_d[63:32]  = bus.kx_round_key;
                            default: rk_data_d[31:0]   = bus.kx_round_key;
                        endcase
                        if (slot_q == 2'd3) begin
                            state_d = ST_PRESENT;
                            slot_d  = 2'd0;
                        end else begin
                            kx_next_s = 1'b1;
                            slot_d    = slot_q + 2'd1;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (!bus.rk_ready) begin
                        state_d = ST_PRESENT;
                    end else if (rk_round_q == LAST_RND) begin
                        state_d = ST_DONE;
                    end else begin
                        // Moves the expander from word 3 onto the next round's word 0.
                        kx_next_s  = 1'b1;
                        rk_round_d = rk_round_q + 4'd1;
                        state_d    = ST_GATHER;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    slot_d  = 2'd0;
                end
            endcase
        end
    end

    // State, slot counter and round-key registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            slot_q     <= 2'd0;
            rk_data_q  <= 128'd0;
            rk_round_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            rk_data_q  <= rk_data_d;
            rk_round_q <= rk_round_d;
        end
    end

`ifdef AES_RKSEQ_CHECK_EN
    // Sticky sequence-error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= seq_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// Bench for aes_round_key_sequencer: AES-128 expander model, round-count reference
// model checked every cycle, directed scenarios plus a randomized phase.
module tb_aes_round_key_sequencer;

    localparam int LAST = 10;
    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK_A1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_chk = 0;
    int n_pass = 0;

    logic [7:0]   sbox [256];
    logic [31:0]  w [64];
    logic [127:0] e_key = 128'd0;
    int           e_addr = 0;
    logic         skip_req = 1'b0;

    bit m_loaded = 1'b0;
    int m_need = 0;
    int m_round = 0;
    bit m_err = 1'b0;
    logic e_valid, e_start, e_next, e_mism;

    aes_round_key_sequencer_if bif ();

    aes_round_key_sequencer #(.LAST_ROUND(LAST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    assign bif.kx_round_key = w[e_addr];
    assign bif.kx_word_addr = 6'(e_addr);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
        return (x << s) | (x >> (8 - s));
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 64; i++) w[i] = 32'h0;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i - 4] ^ t;
        end
    endtask

    always @(e_key) expand_key(e_key);

    // Reference expectations: a load needs four ready beats, then a key is shown until taken.
    assign e_valid = m_loaded && (m_need == 0);
    assign e_start = !m_loaded && bif.key_load && !bif.abort;
`ifdef AES_RKSEQ_CHECK_EN
    assign e_mism = m_loaded && (m_need > 0) && bif.kx_ready && (e_addr != 4 * m_round + 4 - m_need);
`else
    assign e_mism = 1'b0;
`endif
    assign e_next = m_loaded && !bif.abort &&
                    ((m_need > 1 && bif.kx_ready && !e_mism) ||
                     (m_need == 0 && bif.rk_ready && m_round < LAST));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loaded <= 1'b0;
            m_need   <= 0;
            m_round  <= 0;
            m_err    <= 1'b0;
            e_addr   <= 0;
        end else begin
            if (e_start) begin
                e_addr <= 0;
                e_key  <= bif.key_in;
            end else if (e_next) begin
                e_addr <= e_addr + (skip_req ? 2 : 1);
            end
            if (bif.abort) begin
                m_loaded <= 1'b0;
            end else if (!m_loaded) begin
                if (bif.key_load) begin
                    m_loaded <= 1'b1;
                    m_need   <= 4;
                    m_round  <= 0;
                    m_err    <= 1'b0;
                end
            end else if (m_need > 0) begin
                if (bif.kx_ready) begin
                    if (e_mism) begin
                        m_err    <= 1'b1;
                        m_loaded <= 1'b0;
                    end else begin
                        m_need <= m_need - 1;
                    end
                end
            end else if (bif.rk_ready) begin
                if (m_round == LAST) m_loaded <= 1'b0;
                else begin
                    m_round <= m_round + 1;
                    m_need  <= 4;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("rk_valid", 128'(bif.rk_valid), 128'(e_valid));
        chk("key_ready", 128'(bif.key_ready), 128'(!m_loaded));
        chk("busy", 128'(bif.busy), 128'(m_loaded));
        chk("kx_start", 128'(bif.kx_start), 128'(e_start));
        chk("kx_next", 128'(bif.kx_next), 128'(e_next));
        chk("rk_round", 128'(bif.rk_round), 128'(m_round));
        chk("rk_last", 128'(bif.rk_last), 128'(e_valid && m_round == LAST));
        chk("kx_key", bif.kx_key, bif.key_in);
        chk("seq_err", 128'(bif.seq_err), 128'(m_err));
        if (e_valid)
            chk("rk_data", bif.rk_data,
                {w[4 * m_round], w[4 * m_round + 1], w[4 * m_round + 2], w[4 * m_round + 3]});
        if (!rst_n) chk("rk_data_rst", bif.rk_data, 128'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_and_time(input logic [127:0] k, output int lat);
        bif.key_in   = k;
        bif.key_load = 1'b1;
        step();
        bif.key_load = 1'b0;
        lat = 1;
        while (!bif.rk_valid && lat < 30) begin
            step();
            lat++;
        end
    endtask

    task automatic wait_idle(input int max);
        int i = 0;
        while (!bif.key_ready && i < max) begin
            step();
            i++;
        end
        chk("idle_reached", 128'(bif.key_ready), 128'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int lat, cnt, last_n, s3, s4, hold, found;
        bif.key_load = 1'b0;
        bif.key_in   = 128'd0;
        bif.abort    = 1'b0;
        bif.kx_ready = 1'b1;
        bif.rk_ready = 1'b1;
        build_sbox();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_key_ready", 128'(bif.key_ready), 128'd1);
        chk("reset_rk_data", bif.rk_data, 128'd0);

        // Full schedule with the reference key.
        bif.key_in   = KEY_A;
        bif.key_load = 1'b1;
        step();
        bif.key_load = 1'b0;
        chk("model_w4", {w[4], w[5], w[6], w[7]}, RK_A1);
        chk("model_w40", {w[40], w[41], w[42], w[43]}, RK_A10);
        cnt = 0; last_n = 0;
        for (int n = 1; n <= 70; n++) begin
            if (bif.rk_valid) begin
                cnt++;
                last_n = n;
                if (cnt == 1) begin
                    chk("first_latency", 128'(n), 128'd5);
                    chk("round0_data", bif.rk_data, KEY_A);
                end
                if (bif.rk_round == 4'd1) chk("round1_data", bif.rk_data, RK_A1);
                if (bif.rk_round == 4'd10) begin
                    chk("round10_data", bif.rk_data, RK_A10);
                    chk("round10_last", 128'(bif.rk_last), 128'd1);
                end
            end
            if (bif.key_ready && cnt > 0) break;
            step();
        end
        chk("key_count", 128'(cnt), 128'd11);
        chk("last_key_cycle", 128'(last_n), 128'd55);
        chk("done_key_ready", 128'(bif.key_ready), 128'd1);

        // Consumer back-pressure during round 3.
        bif.key_in = KEY_A; bif.key_load = 1'b1;
        step();
        bif.key_load = 1'b0;
        s3 = 0; s4 = 0; hold = 0;
        for (int n = 1; n <= 150; n++) begin
            if (bif.rk_valid && bif.rk_round == 4'd3) begin
                if (s3 == 0) s3 = n;
                if (hold < 7) begin bif.rk_ready = 1'b0; hold++; end
                else bif.rk_ready = 1'b1;
            end
            if (bif.rk_valid && bif.rk_round == 4'd4 && s4 == 0) s4 = n;
            if (bif.key_ready && s4 != 0) break;
            step();
        end
        bif.rk_ready = 1'b1;
        chk("stall_round4_gap", 128'(s4 - s3), 128'd12);

        // Expander stall mid-gather.
        bif.key_in = {$urandom, $urandom, $urandom, $urandom};
        bif.key_load = 1'b1;
        step();
        bif.key_load = 1'b0;
        lat = 1;
        while (!bif.rk_valid && lat < 30) begin
            bif.kx_ready = (lat >= 2 && lat <= 4) ? 1'b0 : 1'b1;
            step();
            lat++;
        end
        bif.kx_ready = 1'b1;
        chk("kx_stall_latency", 128'(lat), 128'd8);
        wait_idle(100);

        // Abort while gathering round 5, with a simultaneous load request.
        load_and_time({$urandom, $urandom, $urandom, $urandom}, lat);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (bif.busy && !bif.rk_valid && bif.rk_round == 4'd5) begin found = 1; break; end
            step();
        end
        chk("round5_gather_seen", 128'(found), 128'd1);
        bif.abort = 1'b1; bif.key_load = 1'b1;
        bif.key_in = {$urandom, $urandom, $urandom, $urandom};
        step();
        bif.abort = 1'b0; bif.key_load = 1'b0;
        chk("abort_key_ready", 128'(bif.key_ready), 128'd1);
        chk("abort_round_kept", 128'(bif.rk_round), 128'd5);
        load_and_time({$urandom, $urandom, $urandom, $urandom}, lat);
        chk("reload_latency", 128'(lat), 128'd5);
        wait_idle(100);

        // Asynchronous reset while presenting.
        bif.rk_ready = 1'b0;
        load_and_time({$urandom, $urandom, $urandom, $urandom}, lat);
        chk("present_reached", 128'(bif.rk_valid), 128'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rk_valid", 128'(bif.rk_valid), 128'd0);
        chk("arst_busy", 128'(bif.busy), 128'd0);
        chk("arst_key_ready", 128'(bif.key_ready), 128'd1);
        chk("arst_rk_data", bif.rk_data, 128'd0);
        chk("arst_rk_round", 128'(bif.rk_round), 128'd0);
        #1 rst_n = 1'b1;
        bif.rk_ready = 1'b1;
        step();
        chk("post_rst_key_ready", 128'(bif.key_ready), 128'd1);

`ifdef AES_RKSEQ_CHECK_EN
        // Expander skips a word on its first advance.
        skip_req = 1'b1;
        bif.key_in = KEY_A; bif.key_load = 1'b1;
        step();
        bif.key_load = 1'b0;
        step();
        skip_req = 1'b0;
        step();
        chk("seq_err_set", 128'(bif.seq_err), 128'd1);
        chk("seq_err_idle", 128'(bif.key_ready), 128'd1);
        repeat (3) step();
        chk("seq_err_sticky", 128'(bif.seq_err), 128'd1);
        bif.key_load = 1'b1;
        step();
        bif.key_load = 1'b0;
        chk("seq_err_cleared", 128'(bif.seq_err), 128'd0);
        wait_idle(100);
`endif

        // Randomized traffic, including ignored loads and aborts.
        repeat (1500) begin
            bif.kx_ready = ($urandom % 4) != 0;
            bif.rk_ready = ($urandom % 3) != 0;
            bif.abort    = ($urandom % 97) == 0;
            bif.key_load = ($urandom % 8) == 0;
            if (bif.key_load) bif.key_in = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        bif.abort = 1'b0; bif.key_load = 1'b0; bif.kx_ready = 1'b1; bif.rk_ready = 1'b1;
        wait_idle(100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
